// File: rtl/collector_2ch_32bit_if.sv
// Channel-side and output-side handshake bundle for the 2-channel collector.
// slave = collector view, master = source/sink view.
interface collector_2ch_32bit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0]   ch1_data;
  logic                ch1_valid;
  logic                ch1_ready;
  logic [DATA_W-1:0]   ch2_data;
  logic                ch2_valid;
  logic                ch2_ready;
  logic [2*DATA_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_W-1:0]    pair_cnt;

  modport slave (
    input  ch1_data, ch1_valid,
    output ch1_ready,
    input  ch2_data, ch2_valid,
    output ch2_ready,
    output out_data, out_valid,
    input  out_ready,
    output pair_cnt
  );

  modport master (
    output ch1_data, ch1_valid,
    input  ch1_ready,
    output ch2_data, ch2_valid,
    input  ch2_ready,
    input  out_data, out_valid,
    output out_ready,
    input  pair_cnt
  );
endinterface

// File: rtl/collector_2ch_32bit.sv
// Pairs one sample per channel into a {ch1,ch2} word; 2-cycle latency, 1 word/cycle.
// Backpressure: one word in the output reg plus one pair in the hold regs, then ch ready drops.
module collector_2ch_32bit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  collector_2ch_32bit_if.slave io_bus
);

  typedef struct packed {
    logic [DATA_W-1:0] ch1;
    logic [DATA_W-1:0] ch2;
  } pair_t;

  logic [DATA_W-1:0] r_h1;
  logic [DATA_W-1:0] r_h2;
  logic              r_f1;
  logic              r_f2;
  pair_t             r_o;
  logic              r_ov;
  logic [CNT_W-1:0]  r_cnt;

  logic w_xfer;
  logic w_pop;
  logic w_rdy1;
  logic w_rdy2;
  logic w_acc1;
  logic w_acc2;

  // Hold regs drain into the output reg when it is empty or being emptied this cycle,
  // so a full hold reg can still take a fresh sample in the same cycle it transfers.
  assign w_xfer = r_f1 & r_f2 & (~r_ov | io_bus.out_ready);
  assign w_pop  = r_ov & io_bus.out_ready;
  assign w_rdy1 = ~r_f1 | w_xfer;
  assign w_rdy2 = ~r_f2 | w_xfer;
  assign w_acc1 = io_bus.ch1_valid & w_rdy1;
  assign w_acc2 = io_bus.ch2_valid & w_rdy2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h1  <= '0;
      r_h2  <= '0;
      r_f1  <= 1'b0;
      r_f2  <= 1'b0;
      r_o   <= '0;
      r_ov  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_acc1) r_h1 <= io_bus.ch1_data;
      if (w_acc2) r_h2 <= io_bus.ch2_data;
      r_f1 <= w_acc1 | (r_f1 & ~w_xfer);
      r_f2 <= w_acc2 | (r_f2 & ~w_xfer);

      if (w_xfer) begin
        r_o.ch1 <= r_h1;
        r_o.ch2 <= r_h2;
      end
      r_ov <= w_xfer | (r_ov & ~w_pop);

      if (w_pop) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign io_bus.ch1_ready = w_rdy1;
  assign io_bus.ch2_ready = w_rdy2;
  assign io_bus.out_data  = r_o;
  assign io_bus.out_valid = r_ov;
  assign io_bus.pair_cnt  = r_cnt;

endmodule

// File: tb/tb_collector_2ch_32bit.sv
// Directed bench for collector_2ch_32bit: reset, pairing, skew, backpressure, wrap, mid-reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_collector_2ch_32bit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  collector_2ch_32bit_if #(.DATA_W(32), .CNT_W(16)) bus ();

  collector_2ch_32bit #(.DATA_W(32), .CNT_W(16)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.ch1_valid = 1'b0;
    bus.ch2_valid = 1'b0;
    bus.ch1_data  = '0;
    bus.ch2_data  = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    n_cmp++; if (bus.pair_cnt !== 16'h0) begin n_err++; $display("FAIL reset_pair_cnt: got %h expected 0", bus.pair_cnt); end
    n_cmp++; if (bus.ch1_ready !== 1'b1) begin n_err++; $display("FAIL reset_ch1_ready: got %b expected 1", bus.ch1_ready); end
    n_cmp++; if (bus.ch2_ready !== 1'b1) begin n_err++; $display("FAIL reset_ch2_ready: got %b expected 1", bus.ch2_ready); end
  endtask

  task automatic test_single_pair();
    apply_reset();
    bus.out_ready = 1'b1;
    bus.ch1_valid = 1'b1; bus.ch1_data = 32'h12345678;
    bus.ch2_valid = 1'b1; bus.ch2_data = 32'h9ABCDEF0;
    #1;
    n_cmp++; if (bus.ch1_ready !== 1'b1) begin n_err++; $display("FAIL single_ch1_ready: got %b expected 1", bus.ch1_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %b expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 64'h123456789ABCDEF0) begin n_err++; $display("FAIL single_out_data: got %h expected 123456789abcdef0", bus.out_data); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_one_cycle: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.pair_cnt !== 16'd1) begin n_err++; $display("FAIL single_pair_cnt: got %0d expected 1", bus.pair_cnt); end
  endtask

  task automatic test_skew();
    int bad_rdy;
    int extra;
    apply_reset();
    bus.out_ready = 1'b1;
    bus.ch1_valid = 1'b1; bus.ch1_data = 32'hAAAA0001;
    @(negedge clk);
    bad_rdy = 0;
    // ch1 keeps offering a different value; it must not replace the held sample
    for (int c = 1; c <= 5; c++) begin
      bus.ch1_valid = 1'b1; bus.ch1_data = 32'hDEADBEEF;
      bus.ch2_valid = (c == 5); bus.ch2_data = 32'h55550002;
      #1;
      if (bus.ch1_ready !== 1'b0) bad_rdy++;
      @(negedge clk);
    end
    n_cmp++; if (bad_rdy !== 0) begin n_err++; $display("FAIL skew_ch1_ready: %0d cycles high, expected 0", bad_rdy); end
    idle_inputs();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL skew_early_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL skew_out_valid: got %b expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 64'hAAAA000155550002) begin n_err++; $display("FAIL skew_out_data: got %h expected aaaa000155550002", bus.out_data); end
    extra = 0;
    for (int c = 8; c <= 10; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL skew_extra_words: got %0d expected 0", extra); end
    n_cmp++; if (bus.pair_cnt !== 16'd1) begin n_err++; $display("FAIL skew_pair_cnt: got %0d expected 1", bus.pair_cnt); end
  endtask

  task automatic test_backpressure();
    logic [63:0] got [4];
    int n;
    apply_reset();
    for (int k = 1; k <= 2; k++) begin
      bus.ch1_valid = 1'b1; bus.ch1_data = 32'(k);
      bus.ch2_valid = 1'b1; bus.ch2_data = 32'(32'h100 + k);
      #1;
      n_cmp++; if (bus.ch1_ready !== 1'b1 || bus.ch2_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_pair%0d: got %b%b expected 11", k, bus.ch1_ready, bus.ch2_ready); end
      @(negedge clk);
    end
    bus.ch1_data = 32'h3; bus.ch2_data = 32'h103;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (bus.ch1_ready !== 1'b0 || bus.ch2_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_pair3: got %b%b expected 00", bus.ch1_ready, bus.ch2_ready); end
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0000000100000101) begin n_err++; $display("FAIL bp_hold_word: got %b/%h expected 1/0000000100000101", bus.out_valid, bus.out_data); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.out_valid === 1'b1 && n < 4) begin got[n] = bus.out_data; n++; end
      @(negedge clk);
      idle_inputs();
    end
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL bp_word_count: got %0d expected 3", n); end
    n_cmp++; if (got[0] !== 64'h0000000100000101) begin n_err++; $display("FAIL bp_word0: got %h expected 0000000100000101", got[0]); end
    n_cmp++; if (got[1] !== 64'h0000000200000102) begin n_err++; $display("FAIL bp_word1: got %h expected 0000000200000102", got[1]); end
    n_cmp++; if (got[2] !== 64'h0000000300000103) begin n_err++; $display("FAIL bp_word2: got %h expected 0000000300000103", got[2]); end
    n_cmp++; if (bus.pair_cnt !== 16'd3) begin n_err++; $display("FAIL bp_pair_cnt: got %0d expected 3", bus.pair_cnt); end
  endtask

  task automatic test_back_to_back();
    int errs;
    int stalls;
    logic [31:0] a;
    apply_reset();
    bus.out_ready = 1'b1;
    errs = 0;
    stalls = 0;
    // pair k enters at cycle k and appears on the output at cycle k+2
    for (int k = 0; k < 65537; k++) begin
      bus.ch1_valid = (k < 65535);
      bus.ch2_valid = (k < 65535);
      bus.ch1_data  = 32'(k);
      bus.ch2_data  = ~32'(k);
      #1;
      if (k < 65535 && (bus.ch1_ready !== 1'b1 || bus.ch2_ready !== 1'b1)) stalls++;
      if (k >= 2) begin
        a = 32'(k - 2);
        if (bus.out_valid !== 1'b1 || bus.out_data !== {a, ~a}) errs++;
      end
      @(negedge clk);
    end
    n_cmp++; if (stalls !== 0) begin n_err++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL stream_data: got %0d bad cycles expected 0", errs); end
    idle_inputs();
    #1;
    n_cmp++; if (bus.pair_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_cnt_max: got %h expected ffff", bus.pair_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained: got %b expected 0", bus.out_valid); end
    bus.ch1_valid = 1'b1; bus.ch1_data = 32'hCAFE0001;
    bus.ch2_valid = 1'b1; bus.ch2_data = 32'hCAFE0002;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.pair_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre: got %b/%h expected 1/ffff", bus.out_valid, bus.pair_cnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.pair_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_cnt_zero: got %h expected 0000", bus.pair_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got [4];
    int n;
    apply_reset();
    bus.ch1_valid = 1'b1; bus.ch1_data = 32'hA1;
    bus.ch2_valid = 1'b1; bus.ch2_data = 32'hA2;
    @(negedge clk);
    bus.ch1_data = 32'hBAD; bus.ch2_valid = 1'b0;
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.ch1_ready !== 1'b0) begin n_err++; $display("FAIL mid_setup: got %b/%b expected 1/0", bus.out_valid, bus.ch1_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.ch1_ready !== 1'b1 || bus.ch2_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b%b expected 11", bus.ch1_ready, bus.ch2_ready); end
    bus.out_ready = 1'b1;
    bus.ch1_valid = 1'b1; bus.ch1_data = 32'h1;
    bus.ch2_valid = 1'b1; bus.ch2_data = 32'h2;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (bus.out_valid === 1'b1 && n < 4) begin got[n] = bus.out_data; n++; end
    end
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL mid_word_count: got %0d expected 1", n); end
    n_cmp++; if (got[0] !== 64'h0000000100000002) begin n_err++; $display("FAIL mid_word: got %h expected 0000000100000002", got[0]); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_pair();
    test_skew();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
